// File: rtl/ir_sequencer_if.sv
// Fetch and decode bus between the instruction-pointer sequencer, the
// instruction memory, the decoder and the ALU compare flags.
interface ir_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  o_fetch_req;
  logic [DATA_WIDTH-1:0] o_ir_pointer;
  logic                  i_fetch_ack;
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_device;
  logic [DATA_WIDTH-1:0] i_address;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_flag_larger;
  logic                  i_flag_smaller;
  logic                  i_flag_equal;

  modport master (
    output o_fetch_req, o_ir_pointer,
    input  i_fetch_ack, i_valid, i_device, i_address, i_data,
           i_flag_larger, i_flag_smaller, i_flag_equal
  );

  modport slave (
    input  o_fetch_req, o_ir_pointer,
    output i_fetch_ack, i_valid, i_device, i_address, i_data,
           i_flag_larger, i_flag_smaller, i_flag_equal
  );
endinterface

// File: rtl/ir_sequencer.sv
// Instruction-pointer sequencer: fetches over a req/ack handshake and
// steps, jumps, waits or halts on controller-device instructions.
module ir_sequencer #(
  parameter int unsigned           DATA_WIDTH        = 8,
  parameter logic [DATA_WIDTH-1:0] RST_VECTOR        = '0,
  parameter logic [DATA_WIDTH-1:0] DEVICE_CONTROLLER = DATA_WIDTH'(1),
  parameter logic [DATA_WIDTH-1:0] PORT_JUMP_ADDR    = DATA_WIDTH'(0),
  parameter logic [DATA_WIDTH-1:0] PORT_JUMP_DIRECT  = DATA_WIDTH'(1),
  parameter logic [DATA_WIDTH-1:0] PORT_JUMP_LARGER  = DATA_WIDTH'(2),
  parameter logic [DATA_WIDTH-1:0] PORT_JUMP_SMALLER = DATA_WIDTH'(3),
  parameter logic [DATA_WIDTH-1:0] PORT_JUMP_EQUAL   = DATA_WIDTH'(4),
  parameter logic [DATA_WIDTH-1:0] PORT_JUMP_UNEQUAL = DATA_WIDTH'(5),
  parameter logic [DATA_WIDTH-1:0] PORT_WAIT         = DATA_WIDTH'(6),
  parameter logic [DATA_WIDTH-1:0] PORT_STOP         = DATA_WIDTH'(7)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  ir_sequencer_if.master       bus,
  output logic                 o_stall,
  output logic                 o_halted,
  output logic [2:0]           o_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    WAIT  = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] target_q, target_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] ptr_inc;

  assign ptr_inc = ptr_q + ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= RST_VECTOR;
      target_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      target_q <= target_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    target_d = target_q;
    count_d  = count_q;
    case (state_q)
      IDLE:  if (i_start) state_d = FETCH;
      FETCH: if (bus.i_fetch_ack) state_d = EXEC;
      EXEC: begin
        if (bus.i_valid) begin
          state_d = FETCH;
          ptr_d   = ptr_inc;
          if (bus.i_device == DEVICE_CONTROLLER) begin
            case (bus.i_address)
              PORT_JUMP_ADDR:    target_d = bus.i_data;
              PORT_JUMP_DIRECT:  ptr_d = target_q;
              PORT_JUMP_LARGER:  if (bus.i_flag_larger) ptr_d = target_q;
              PORT_JUMP_SMALLER: if (bus.i_flag_smaller) ptr_d = target_q;
              PORT_JUMP_EQUAL:   if (bus.i_flag_equal) ptr_d = target_q;
              PORT_JUMP_UNEQUAL: if (!bus.i_flag_equal) ptr_d = target_q;
              PORT_WAIT: begin
                // The pointer only advances when the wait expires.
                if (bus.i_data != '0) begin
                  count_d = bus.i_data;
                  ptr_d   = ptr_q;
                  state_d = WAIT;
                end
              end
              PORT_STOP:         state_d = HALT;
              default:           ;
            endcase
          end
        end
      end
      WAIT: begin
        count_d = count_q - ONE;
        if (count_q <= ONE) begin
          ptr_d   = ptr_inc;
          state_d = FETCH;
        end
      end
      HALT:  if (i_start) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_fetch_req  = (state_q == FETCH);
  assign bus.o_ir_pointer = ptr_q;
  assign o_stall          = (state_q == WAIT);
  assign o_halted         = (state_q == HALT);
  assign o_state          = state_q;

endmodule

// File: doc/ir_sequencer.md
Name: ir_sequencer

Overview:
- Instruction-pointer sequencer for the core. It fetches instructions from instruction memory through a req/ack handshake, and it steps, jumps, waits or halts according to controller-device instructions.
- Handles every `DEVICE_CONTROLLER` port: JUMP_ADDR, JUMP_DIRECT, JUMP_LARGER, JUMP_SMALLER, JUMP_EQUAL, JUMP_UNEQUAL, WAIT and STOP.
- Sits between the instruction decoder, the ALU compare flags and the instruction memory.

Parameters:
- DATA_WIDTH, 8, width of device/address/data fields and of the instruction pointer.
- RST_VECTOR, 0, value loaded into the instruction pointer at reset.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  reset, asynchronous, active-low.
- i_start  input  1  run pulse; acted on only in IDLE or HALT.
- i_fetch_ack  input  1  instruction memory has returned the word at o_ir_pointer.
- i_valid  input  1  decoder presents a decoded instruction on i_device/i_address/i_data.
- i_device  input  DATA_WIDTH  decoded device field.
- i_address  input  DATA_WIDTH  decoded port/address field.
- i_data  input  DATA_WIDTH  decoded immediate (jump target or wait count).
- i_flag_larger  input  1  ALU compare result a>b.
- i_flag_smaller  input  1  ALU compare result a<b.
- i_flag_equal  input  1  ALU compare result a==b.
- o_fetch_req  output  1  fetch request; o_ir_pointer is the address.
- o_ir_pointer  output  DATA_WIDTH  current instruction pointer.
- o_stall  output  1  high while in WAIT.
- o_halted  output  1  high while in HALT.
- o_state  output  3  current state encoding, for debug.

Behaviour:
- Reset values: state=IDLE, o_ir_pointer=RST_VECTOR, target register=0, wait counter=0, o_fetch_req=0, o_stall=0, o_halted=0.
- Reset is honoured in any state, including mid-fetch and mid-wait.
- State encodings: IDLE=0, FETCH=1, EXEC=2, WAIT=3, HALT=4. All other codes return to IDLE on the next clock.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- IDLE: on i_start go to FETCH. o_ir_pointer is unchanged.
- FETCH:
  - o_fetch_req=1 and o_ir_pointer is held stable.
  - On i_fetch_ack go to EXEC and drop o_fetch_req the next cycle.
  - There is no timeout.
- EXEC: wait for i_valid. When i_valid=1, act in that cycle; the update is visible next cycle.
  - i_device != `DEVICE_CONTROLLER`, or an unlisted port: pointer+1, go to FETCH.
  - PORT_JUMP_ADDR: target<=i_data, pointer+1, go to FETCH.
  - PORT_JUMP_DIRECT: pointer<=target, go to FETCH.
  - PORT_JUMP_LARGER / SMALLER / EQUAL: pointer<=target if the matching flag is 1, else pointer+1; go to FETCH.
  - PORT_JUMP_UNEQUAL: pointer<=target if i_flag_equal=0, else pointer+1; go to FETCH.
  - Only the flag matching the port is examined; other flags are don't-care.
  - PORT_WAIT with i_data=0: behaves as a no-op (pointer+1, go to FETCH).
  - PORT_WAIT with i_data=N>0: counter<=N, go to WAIT.
  - PORT_STOP: pointer+1, go to HALT.
- WAIT:
  - o_stall=1 and the counter decrements each cycle.
  - When counter==1: pointer+1, go to FETCH.
  - Total cycles spent in WAIT = N exactly.
  - i_valid and i_start are ignored.
- HALT: o_halted=1. On i_start go to FETCH at the already-incremented pointer.
- Pointer arithmetic is modulo 2^DATA_WIDTH; 0xFF+1 wraps to 0x00 with no flag.
- The target register persists across jumps and HALT and is cleared only by reset.
- JUMP_ADDR immediately followed by JUMP_DIRECT uses the newly loaded target.
- i_start outside IDLE/HALT is ignored.
- i_fetch_ack outside FETCH is ignored.
- i_valid outside EXEC is ignored.

Test Plan:
- Reset then fetch:
  - Stimulus: RST_VECTOR=0x10; deassert rst_n; pulse i_start; ack the fetch; issue a non-controller instruction.
  - Response: o_fetch_req=1 with pointer 0x10; then pointer=0x11 and o_fetch_req=1 again.
- Address load and direct jump:
  - Stimulus: JUMP_ADDR with i_data=0x40; next instruction JUMP_DIRECT.
  - Response: pointer advances 0x00→0x01, then the next fetch is at 0x40.
- Conditional jumps with target=0x20:
  - JUMP_EQUAL with equal=1 → pointer 0x20.
  - JUMP_EQUAL with equal=0 → pointer+1.
  - JUMP_UNEQUAL with equal=0 → 0x20.
  - JUMP_LARGER with larger=0 and smaller=1 → pointer+1.
- Wait counting:
  - WAIT i_data=3 → o_stall high for exactly 3 cycles, then o_fetch_req at pointer+1.
  - WAIT i_data=0 → no stall cycle.
- Stop and resume plus wrap:
  - Pointer 0xFF, STOP → o_halted=1, pointer=0x00.
  - i_start → fetch at 0x00.
  - i_start pulsed during FETCH has no effect.
- Reset mid-operation:
  - Stimulus: assert rst_n low asynchronously during WAIT with counter=5.
  - Response: outputs go to reset values immediately, without a clock edge; after release the block stays in IDLE until i_start.
